vector_mac: RTL
===============

# vector_mac

Parametrised, pipelined multi-lane signed multiply-and-accumulate engine. It succeeds the single-lane 8×8 `digital_MAC` used in the CNN datapath. Each accepted beat performs `LANES` products and an adder-tree sum, and accumulates beats into a bias-initialised accumulator until `in_last`. It then applies optional ReLU and saturation and holds the neuron/pixel result under a valid/ready handshake for the layer controller.

## Interface
- `DATA_W`, 8, signed activation width per lane
- `WEIGHT_W`, 8, signed weight width per lane
- `LANES`, 4, parallel multipliers (power of 2, ≥1)
- `ACC_W`, 24, signed accumulator width (≥ `DATA_W+WEIGHT_W+log2(LANES)`)
- `OUT_W`, 16, signed output width (≤ `ACC_W`)
- `RELU`, 1, 1 = clamp negative results to 0

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  beat present
- `in_ready`  out  1  block accepts beat; a beat transfers when `in_valid & in_ready`
- `in_last`  in  1  final beat of current vector
- `data_in`  in  `LANES*DATA_W`  lane i = bits `[i*DATA_W +: DATA_W]`, signed
- `weight_in`  in  `LANES*WEIGHT_W`  same packing, signed
- `bias_in`  in  `ACC_W`  signed; sampled on the first beat of a vector only
- `out_valid`  out  1  result held
- `out_ready`  in  1  consumer accepts result
- `data_out`  out  `OUT_W`  signed result
- `sat`  out  1  result was clipped (accumulator or output saturation); valid with `out_valid`

## Operation
- FSM states: IDLE, ACCUM, DRAIN, HOLD.
- IDLE: `in_ready`=1. On an accepted beat, the accumulator source is set to `bias_in`. Go to ACCUM, or to DRAIN if `in_last`.
- ACCUM: `in_ready`=1. Subsequent beats are accepted and accumulated. An accepted `in_last` moves the FSM to DRAIN. Cycles with `in_valid`=0 are bubbles; the vector is not aborted.
- DRAIN: `in_ready`=0. A counter runs until the last beat leaves the pipeline, then the FSM moves to HOLD.
- HOLD: `out_valid`=1. `data_out` and `sat` stay stable until `out_ready`=1, then the FSM returns to IDLE.
- Pipeline stages:
  - P1: registered lane products, each `DATA_W+WEIGHT_W` signed.
  - P2: registered adder-tree sum, sign-extended to `ACC_W`.
  - P3: accumulator.
  - P4: post-process into the output register.
- Accumulator arithmetic:
  - First beat: acc = bias + sum.
  - Later beats: acc = acc + sum.
  - On signed overflow, acc saturates to ±(2^(ACC_W-1)) bound and sets a sticky `acc_ovf` for the vector.
- Post-process:
  - If `RELU`=1 and acc<0, the value becomes 0.
  - The value is then clamped to [−2^(OUT_W-1), 2^(OUT_W-1)−1].
  - `sat` = `acc_ovf` OR clamp active. A ReLU zero alone does not set `sat`.
- `acc_ovf` clears at the first beat of each vector.
- Single-beat vectors (first beat with `in_last`=1) are legal.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 in the first cycle after; `out_valid`=0, `data_out`=0, `sat`=0. FSM goes to IDLE and the accumulator, pipeline registers and counters are cleared.
- Latency: `out_valid` rises on the 4th rising edge after the edge that accepts the `in_last` beat.
- Throughput: one vector per (beats + 5) cycles minimum. No overlap between vectors.
- Handshake:
  - `out_valid` falls on the edge following a cycle with `out_valid & out_ready`.
  - `in_ready` rises on that same edge.
  - `out_ready` asserted early, in DRAIN, has no effect.
- Reset mid-operation (any state): everything in flight is discarded and no `out_valid` is produced for that vector.
- `in_valid` while `in_ready`=0: ignored; the bench/controller must hold the beat.
- Bias is ignored on non-first beats, even if it changes.

## Test plan
- **Single beat.** LANES=4, data {1,2,3,4}, weights {5,6,7,8}, bias 0, `in_last`=1, `out_ready`=1. Expect `data_out`=70, `sat`=0, `out_valid` exactly 4 edges after acceptance, for 1 cycle.
- **Multi-beat with ReLU.** 3 beats of data all −3, weights all 2, bias 10. With `RELU`=1: `data_out`=0, `sat`=0. With `RELU`=0: `data_out`=−62.
- **Output clamp.** One beat, data all 127, weights all 127 (sum 64516); also one beat of all −128 × −128 (65536). Expect `data_out`=32767, `sat`=1 in both cases. Then data all −128, weights all 127 (sum −65024), `RELU`=0: expect −32768, `sat`=1.
- **Backpressure and bubbles.** 2-beat vector with an `in_valid` gap between beats; `out_ready` held low 5 cycles after `out_valid`. Expect `data_out` stable, `in_ready`=0 throughout HOLD, a single result on release, and `in_ready`=1 on the next cycle.
- **Reset mid-DRAIN.** `reset` pulsed 2 cycles after `in_last` acceptance. Expect no `out_valid` and all outputs at reset values. The next vector ({1,1,1,1}·{2,2,2,2}, bias 1) gives 9.
- **Bias sampling.** 2-beat vector with bias 5 on beat 1 and bias 100 on beat 2, data {1,0,0,0}, weights {1,0,0,0}. Expect 7.

Source files
------------

// File: rtl/vector_mac.sv
// Multi-lane signed MAC: lane products -> adder tree -> saturating bias-seeded
// accumulator -> ReLU/clamp output register held under a valid/ready handshake.

module vmac_lane #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         en_i,
   input  logic [DATA_W-1:0]            a_i,
   input  logic [WEIGHT_W-1:0]          b_i,
   output logic [DATA_W+WEIGHT_W-1:0]   prod_o
);
   logic signed [DATA_W+WEIGHT_W-1:0] prod_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)     prod_q <= '0;
      else if (en_i) prod_q <= $signed(a_i) * $signed(b_i);
   end

   assign prod_o = prod_q;
endmodule

module vector_mac #(
   parameter int DATA_W   = 8,
   parameter int WEIGHT_W = 8,
   parameter int LANES    = 4,
   parameter int ACC_W    = 24,
   parameter int OUT_W    = 16,
   parameter int RELU     = 1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_last,
   input  logic [LANES*DATA_W-1:0]      data_in,
   input  logic [LANES*WEIGHT_W-1:0]    weight_in,
   input  logic [ACC_W-1:0]             bias_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_W-1:0]             data_out,
   output logic                         sat
);
   localparam int PW = DATA_W + WEIGHT_W;
   localparam logic [1:0] DRAIN_LAST = 2'd3;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_e;

   state_e                    state_q;
   logic [1:0]                drain_cnt_q;
   logic                      in_ready_q, out_valid_q, sat_q;
   logic [OUT_W-1:0]          data_out_q;
   logic                      accept, first_beat;

   logic [LANES-1:0][PW-1:0]  prod_q;
   logic [1:0]                vld_pipe_q, first_pipe_q;
   logic signed [ACC_W-1:0]   tree_sum, sum_q, bias_q, acc_q, acc_base;
   logic signed [ACC_W:0]     acc_sum;
   logic                      add_ovf, acc_ovf_q;
   logic signed [ACC_W-1:0]   relu_val;
   logic [OUT_W-1:0]          pp_data;
   logic                      pp_clip, pp_sat;

   // in_ready_q already holds the post-reset value; masking keeps it low while reset is high
   assign in_ready   = in_ready_q & ~reset;
   assign accept     = in_valid & in_ready;
   assign first_beat = accept && (state_q == IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         vmac_lane #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W)) u_lane (
            .clk_i  (clock),
            .rst_i  (reset),
            .en_i   (accept),
            .a_i    (data_in[gi*DATA_W +: DATA_W]),
            .b_i    (weight_in[gi*WEIGHT_W +: WEIGHT_W]),
            .prod_o (prod_q[gi])
         );
      end
   endgenerate

   // Heap-indexed tree: leaves at [LANES..2*LANES-1], root at [1]
   always_comb begin : tree
      logic signed [ACC_W-1:0] nd [1:2*LANES-1];
      for (int i = 0; i < LANES; i++) nd[LANES+i] = ACC_W'(signed'(prod_q[i]));
      for (int i = LANES-1; i >= 1; i--) nd[i] = nd[2*i] + nd[2*i+1];
      tree_sum = nd[1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_pipe_q   <= '0;
         first_pipe_q <= '0;
         sum_q        <= '0;
         bias_q       <= '0;
      end else begin
         vld_pipe_q   <= {vld_pipe_q[0], accept};
         first_pipe_q <= {first_pipe_q[0], first_beat};
         if (vld_pipe_q[0]) sum_q  <= tree_sum;
         if (first_beat)    bias_q <= bias_in;
      end
   end

   always_comb begin
      acc_base = first_pipe_q[1] ? bias_q : acc_q;
      acc_sum  = {acc_base[ACC_W-1], acc_base} + {sum_q[ACC_W-1], sum_q};
      add_ovf  = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q     <= '0;
         acc_ovf_q <= 1'b0;
      end else if (vld_pipe_q[1]) begin
         if (add_ovf) acc_q <= acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
         else         acc_q <= acc_sum[ACC_W-1:0];
         acc_ovf_q <= add_ovf | (acc_ovf_q & ~first_pipe_q[1]);
      end
   end

   // ReLU zero is not a clip; only the output-range clamp or accumulator overflow sets sat
   always_comb begin
      relu_val = (RELU != 0 && acc_q[ACC_W-1]) ? '0 : acc_q;
      pp_clip  = 1'b1;
      if (relu_val > OUT_MAX)      pp_data = OUT_MAX[OUT_W-1:0];
      else if (relu_val < OUT_MIN) pp_data = OUT_MIN[OUT_W-1:0];
      else begin
         pp_data = relu_val[OUT_W-1:0];
         pp_clip = 1'b0;
      end
      pp_sat = acc_ovf_q | pp_clip;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         drain_cnt_q <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_out_q  <= '0;
         sat_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               state_q     <= in_last ? DRAIN : ACCUM;
               in_ready_q  <= ~in_last;
               drain_cnt_q <= '0;
            end
            ACCUM: if (accept && in_last) begin
               state_q     <= DRAIN;
               in_ready_q  <= 1'b0;
               drain_cnt_q <= '0;
            end
            // Last beat needs P1, P2, P3, then the clamp reads the settled accumulator
            DRAIN: begin
               drain_cnt_q <= drain_cnt_q + 2'd1;
               if (drain_cnt_q == DRAIN_LAST) begin
                  state_q     <= HOLD;
                  out_valid_q <= 1'b1;
                  data_out_q  <= pp_data;
                  sat_q       <= pp_sat;
               end
            end
            HOLD: if (out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign data_out  = data_out_q;
   assign sat       = sat_q;
endmodule
